// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// pong_game_ctrl : sequences the ball through idle/serve/play/miss/over,
//                  gates the frame tick and keeps BCD score and lives.
// Revision: 1.0
// ============================================================================
module pong_game_ctrl #(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int MISS_FRAMES  = 30,
   parameter int MAX_Y        = 480,
   parameter int BALL_SIZE    = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       refr_tick_i,
   input  logic       start_btn_i,
   input  logic       pause_btn_i,
   input  logic [9:0] ball_y_i,
   input  logic       paddle_hit_i,
   output logic       ball_tick_o,
   output logic       ball_hold_o,
   output logic [7:0] score_o,
   output logic [1:0] lives_o,
   output logic [2:0] state_o,
   output logic       game_over_o
);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_serve = 3'd1;
   localparam logic [2:0] c_play  = 3'd2;
   localparam logic [2:0] c_miss  = 3'd3;
   localparam logic [2:0] c_over  = 3'd4;

   localparam logic [9:0] c_miss_y     = 10'(MAX_Y - BALL_SIZE);
   localparam logic [6:0] c_serve_last = 7'(SERVE_FRAMES - 1);
   localparam logic [6:0] c_miss_last  = 7'(MISS_FRAMES - 1);
   localparam logic [1:0] c_lives      = 2'(LIVES);

   logic [2:0] state_q, state_d;
   logic       start_q, pause_q;
   logic       paused_q, paused_d;
   logic [6:0] frame_cnt_q, frame_cnt_d;
   logic [7:0] score_q, score_d;
   logic [1:0] lives_q, lives_d;
   logic       ball_hold_q, ball_hold_d;
   logic       game_over_q, game_over_d;

   logic w_start_edge, w_pause_edge, w_run, w_hit, w_miss;

   assign w_start_edge = start_btn_i & ~start_q;
   assign w_pause_edge = pause_btn_i & ~pause_q;
   assign w_run        = (state_q == c_play) & ~paused_q;
   assign w_hit        = w_run & paddle_hit_i;
   // A hit in the same cycle as a miss condition wins; the miss is retried next frame.
   assign w_miss       = w_run & ~paddle_hit_i & refr_tick_i & (ball_y_i >= c_miss_y);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= c_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle:  if (w_start_edge) state_d = c_serve;
         c_serve: if (refr_tick_i && frame_cnt_q == c_serve_last) state_d = c_play;
         c_play:  if (w_miss) state_d = c_miss;
         c_miss:  if (refr_tick_i && frame_cnt_q == c_miss_last)
                     state_d = (lives_q == 2'd0) ? c_over : c_serve;
         c_over:  if (w_start_edge) state_d = c_serve;
         default: state_d = c_idle;
      endcase
   end

   // Hold and game-over are derived from the next state so they change with state_o.
   always_comb begin
      ball_tick_o = refr_tick_i & (state_q == c_play) & ~paused_q;
      ball_hold_d = (state_d != c_play) && (state_d != c_miss);
      game_over_d = (state_d == c_over);
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (state_d != state_q)
         frame_cnt_d = '0;
      else if (refr_tick_i && (state_q == c_serve || state_q == c_miss))
         frame_cnt_d = frame_cnt_q + 7'd1;

      paused_d = paused_q;
      if (state_d != c_play)
         paused_d = 1'b0;
      else if (state_q == c_play && w_pause_edge)
         paused_d = ~paused_q;

      score_d = score_q;
      lives_d = lives_q;
      if (state_q == c_idle || (state_q == c_over && w_start_edge)) begin
         score_d = 8'h00;
         lives_d = c_lives;
      end else begin
         if (w_hit && score_q != 8'h99) begin
            if (score_q[3:0] == 4'd9)
               score_d = {score_q[7:4] + 4'd1, 4'd0};
            else
               score_d = {score_q[7:4], score_q[3:0] + 4'd1};
         end
         if (w_miss && lives_q != 2'd0)
            lives_d = lives_q - 2'd1;
      end
   end

   // Button history resets high so a button held through reset does not fire.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         start_q     <= 1'b1;
         pause_q     <= 1'b1;
         paused_q    <= 1'b0;
         frame_cnt_q <= '0;
         score_q     <= 8'h00;
         lives_q     <= c_lives;
         ball_hold_q <= 1'b1;
         game_over_q <= 1'b0;
      end else begin
         start_q     <= start_btn_i;
         pause_q     <= pause_btn_i;
         paused_q    <= paused_d;
         frame_cnt_q <= frame_cnt_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         ball_hold_q <= ball_hold_d;
         game_over_q <= game_over_d;
      end
   end

   assign ball_hold_o = ball_hold_q;
   assign score_o     = score_q;
   assign lives_o     = lives_q;
   assign state_o     = state_q;
   assign game_over_o = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pong_game_ctrl : randomized scoreboard bench against a game-rule model.
// Revision: 1.0
// ============================================================================
module tb_pong_game_ctrl;

   localparam int LIVES        = 3;
   localparam int SERVE_FRAMES = 60;
   localparam int MISS_FRAMES  = 30;
   localparam int MAX_Y        = 480;
   localparam int BALL_SIZE    = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       refr_tick = 1'b0;
   logic       start_btn = 1'b1;
   logic       pause_btn = 1'b0;
   logic [9:0] ball_y = '0;
   logic       paddle_hit = 1'b0;
   logic       ball_tick, ball_hold, game_over;
   logic [7:0] score;
   logic [1:0] lives;
   logic [2:0] state;

   pong_game_ctrl #(
      .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .MISS_FRAMES(MISS_FRAMES),
      .MAX_Y(MAX_Y), .BALL_SIZE(BALL_SIZE)
   ) dut (
      .clk(clk), .rstn(rstn), .refr_tick_i(refr_tick), .start_btn_i(start_btn),
      .pause_btn_i(pause_btn), .ball_y_i(ball_y), .paddle_hit_i(paddle_hit),
      .ball_tick_o(ball_tick), .ball_hold_o(ball_hold), .score_o(score),
      .lives_o(lives), .state_o(state), .game_over_o(game_over)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       hold;
      logic [7:0] sc;
      logic [1:0] lv;
      logic       ov;
   } exp_t;

   exp_t exp_reg_q[$];
   bit   exp_tick_q[$];
   int   total = 0;
   int   bad   = 0;

   // Game-rule model: phase 0..4, score as a decimal number, ticks seen in phase.
   int m_phase, m_score, m_lives, m_ticks;
   bit m_paused, m_pst, m_ppa;

   task automatic model_reset();
      m_phase = 0; m_score = 0; m_lives = LIVES; m_ticks = 0;
      m_paused = 0; m_pst = 1; m_ppa = 1;
   endtask

   task automatic model_step(input bit st, input bit pa, input bit rf,
                             input int y, input bit hit);
      bit se, pe;
      se = st && !m_pst;
      pe = pa && !m_ppa;
      m_pst = st;
      m_ppa = pa;
      case (m_phase)
         0: if (se) begin m_phase = 1; m_ticks = 0; end
         1: if (rf) begin
               m_ticks++;
               if (m_ticks == SERVE_FRAMES) begin m_phase = 2; m_ticks = 0; end
            end
         2: begin
               if (!m_paused && hit) begin
                  if (m_score < 99) m_score++;
               end else if (!m_paused && rf && y >= MAX_Y - BALL_SIZE) begin
                  m_lives--; m_phase = 3; m_ticks = 0; m_paused = 0;
               end
               if (m_phase == 2 && pe) m_paused = !m_paused;
            end
         3: if (rf) begin
               m_ticks++;
               if (m_ticks == MISS_FRAMES) begin
                  m_phase = (m_lives == 0) ? 4 : 1;
                  m_ticks = 0;
               end
            end
         default: if (se) begin
               m_phase = 1; m_ticks = 0; m_score = 0; m_lives = LIVES;
            end
      endcase
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.st   = 3'(m_phase);
      e.hold = !(m_phase == 2 || m_phase == 3);
      e.sc   = {4'(m_score / 10), 4'(m_score % 10)};
      e.lv   = 2'(m_lives);
      e.ov   = (m_phase == 4);
      return e;
   endfunction

   task automatic step(input bit rn, input bit st, input bit pa, input bit rf,
                       input logic [9:0] y, input bit hit);
      @(posedge clk);
      #2;
      rstn = rn; start_btn = st; pause_btn = pa; refr_tick = rf;
      ball_y = y; paddle_hit = hit;
      exp_tick_q.push_back(rn && rf && m_phase == 2 && !m_paused);
      if (!rn) model_reset();
      else model_step(st, pa, rf, int'(y), hit);
      exp_reg_q.push_back(model_out());
   endtask

   function automatic logic [9:0] safe_y();
      return 10'($urandom_range(MAX_Y - BALL_SIZE - 1, 0));
   endfunction

   function automatic logic [9:0] any_y();
      int r;
      r = $urandom_range(7, 0);
      if (r == 0) return 10'(MAX_Y - BALL_SIZE - 1);
      if (r == 1) return 10'(MAX_Y - BALL_SIZE);
      if (r < 4) return 10'($urandom_range(1023, MAX_Y - BALL_SIZE));
      return safe_y();
   endfunction

   // Registered outputs, sampled just after the active edge.
   initial begin
      exp_t e, got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_reg_q.size() > 0) begin
            e   = exp_reg_q.pop_front();
            got = {state, ball_hold, score, lives, game_over};
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL regs t=%0t: got st=%0d hold=%0b score=%h lives=%0d over=%0b, expected st=%0d hold=%0b score=%h lives=%0d over=%0b",
                        $time, got.st, got.hold, got.sc, got.lv, got.ov,
                        e.st, e.hold, e.sc, e.lv, e.ov);
            end
         end
      end
   end

   // Combinational ball_tick, sampled mid-cycle while inputs are stable.
   initial begin
      bit et;
      forever begin
         @(negedge clk);
         if (exp_tick_q.size() > 0) begin
            et = exp_tick_q.pop_front();
            total++;
            if (ball_tick !== et) begin
               bad++;
               $display("FAIL ball_tick t=%0t: got %0b expected %0b", $time, ball_tick, et);
            end
         end
      end
   end

   initial begin
      bit sl, pl;
      model_reset();
      // Reset with start held, then held after release of reset: stays idle.
      repeat (4) step(0, 1, 0, 0, safe_y(), 0);
      repeat (5) step(1, 1, 0, 1'($urandom_range(1, 0)), safe_y(), 0);
      step(1, 0, 0, 0, safe_y(), 0);
      step(1, 1, 0, 0, safe_y(), 0);
      step(1, 1, 0, 0, safe_y(), 0);
      // Serve then play with dense hits and a safe ball: score climbs to saturation.
      repeat (900) step(1, 1, 0, ($urandom_range(2, 0) == 0), safe_y(),
                        1'($urandom_range(1, 0)));
      // Pause toggling with hits while play continues.
      pl = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(14, 0) == 0) pl = !pl;
         step(1, 1, pl, ($urandom_range(2, 0) == 0), safe_y(), ($urandom_range(2, 0) == 0));
      end
      step(1, 1, 0, 0, safe_y(), 0);
      step(1, 1, 1, 0, safe_y(), 0);
      // Hit coincident with a miss-row frame tick.
      step(1, 1, 1, 1, 10'd475, 1);
      // Free-running random play including misses, game over, restarts and resets.
      sl = 1; pl = 0;
      for (int i = 0; i < 7000; i++) begin
         if ($urandom_range(39, 0) == 0) sl = !sl;
         if ($urandom_range(29, 0) == 0) pl = !pl;
         if ($urandom_range(2999, 0) == 0) begin
            step(0, sl, pl, 0, any_y(), 0);
         end else begin
            step(1, sl, pl, ($urandom_range(2, 0) == 0), any_y(),
                 ($urandom_range(5, 0) == 0));
         end
      end
      // Drive into a miss and reset in the middle of it.
      for (int i = 0; i < 3000 && m_phase != 3; i++) begin
         sl = !sl;
         step(1, sl, 0, ($urandom_range(1, 0) == 0), 10'd500, 0);
      end
      repeat (5) step(1, 0, 0, 1, 10'd500, 0);
      step(0, 0, 0, 0, safe_y(), 0);
      step(0, 0, 0, 1, safe_y(), 0);
      repeat (4) step(1, 0, 0, 1, safe_y(), 0);
      repeat (2) @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
